// File: rtl/csa_fan_stream.sv
// Streaming segmented carry-save reducer: per-beat run sums with runs carried across beats.
// Ports: clk/rst, in_* valid/ready beat (operands, vec_ids, last), out_* beat (sums, sum_valid, ids, spill).
module csa_fan_stream #(
  parameter int N   = 16,
  parameter int W   = 8,
  parameter int V   = 3,
  parameter int EXT = 4,
  localparam int S  = W + $clog2(N) + EXT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_operands,
  input  logic [N*V-1:0] in_vec_ids,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*S-1:0] out_sums,
  output logic [N-1:0]   out_sum_valid,
  output logic [N*V-1:0] out_vec_ids,
  output logic           out_spill_valid,
  output logic [S-1:0]   out_spill_sum,
  output logic [V-1:0]   out_spill_id
);

  logic stall;
  logic adv;

  logic [N-1:0][W-1:0] op_w;
  logic [N-1:0][V-1:0] id_w;

  logic [N-1:0]        end_d;
  logic [N-1:0][S-1:0] cs_s_d;
  logic [N-1:0][S-1:0] cs_c_d;
  logic                s1_merge_d;

  logic                s1_valid_q;
  logic [N-1:0]        s1_end_q;
  logic [N-1:0][S-1:0] s1_s_q;
  logic [N-1:0][S-1:0] s1_c_q;
  logic [N-1:0][V-1:0] s1_ids_q;
  logic                s1_merge_q;

  logic                carry_valid_q;
  logic                carry_valid_d;
  logic [S-1:0]        carry_sum_q;
  logic [S-1:0]        carry_sum_d;
  logic [V-1:0]        carry_id_q;
  logic [V-1:0]        carry_id_d;

  logic [N-1:0][S-1:0] lane_sum;
  logic [N-1:0][S-1:0] sums_d;
  logic [N-1:0]        sum_valid_d;
  logic                spill_d;

  logic                out_valid_q;
  logic [N-1:0][S-1:0] out_sums_q;
  logic [N-1:0]        out_sum_valid_q;
  logic [N-1:0][V-1:0] out_ids_q;
  logic                out_spill_valid_q;
  logic [S-1:0]        out_spill_sum_q;
  logic [V-1:0]        out_spill_id_q;

  assign op_w = in_operands;
  assign id_w = in_vec_ids;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign adv      = s1_valid_q & ~stall;

  // Stage 1: run boundaries and per-lane segmented 3:2 compression.
  always_comb begin : seg_csa
    logic [S-1:0] s;
    logic [S-1:0] c;
    logic [S-1:0] x;
    logic [S-1:0] t;
    logic         live;
    s      = '0;
    c      = '0;
    x      = '0;
    t      = '0;
    live   = 1'b0;
    end_d  = '0;
    cs_s_d = '0;
    cs_c_d = '0;
    for (int j = 0; j < N - 1; j++) begin
      end_d[j] = id_w[j] != id_w[j+1];
    end
    end_d[N-1] = in_last;
    for (int j = 0; j < N; j++) begin
      s    = '0;
      c    = '0;
      live = 1'b1;
      // Walk back from lane j; stop feeding at the previous run end.
      for (int k = j; k >= 0; k--) begin
        if (k < j && end_d[k]) live = 1'b0;
        x = live ? {{(S-W){1'b0}}, op_w[k]} : '0;
        t = s ^ c ^ x;
        c = ((s & c) | (s & x) | (c & x)) << 1;
        s = t;
      end
      cs_s_d[j] = s;
      cs_c_d[j] = c;
    end
  end

  // Stage 2: carry-propagate add; lanes of the lane-0 run absorb the carry.
  always_comb begin : cpa
    logic in0;
    in0         = 1'b1;
    lane_sum    = '0;
    sums_d      = '0;
    sum_valid_d = '0;
    for (int j = 0; j < N; j++) begin
      lane_sum[j] = s1_s_q[j] + s1_c_q[j] +
                    ((in0 && s1_merge_q) ? carry_sum_q : '0);
      if (s1_end_q[j]) in0 = 1'b0;
      sums_d[j] = s1_end_q[j] ? lane_sum[j] : '0;
    end
    if (s1_valid_q) sum_valid_d = s1_end_q;
    if (!s1_valid_q) sums_d = '0;
  end

  assign spill_d = s1_valid_q & carry_valid_q & ~s1_merge_q;

  always_comb begin
    carry_valid_d = carry_valid_q;
    carry_sum_d   = carry_sum_q;
    carry_id_d    = carry_id_q;
    if (adv) begin
      if (s1_end_q[N-1]) begin
        carry_valid_d = 1'b0;
        carry_sum_d   = '0;
        carry_id_d    = '0;
      end else begin
        carry_valid_d = 1'b1;
        carry_sum_d   = lane_sum[N-1];
        carry_id_d    = s1_ids_q[N-1];
      end
    end
  end

  // Compare against the carry as it will be after the beat ahead
  // leaves stage 2, so back-to-back beats need no bubble.
  assign s1_merge_d = carry_valid_d && (id_w[0] == carry_id_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q        <= 1'b0;
      s1_end_q          <= '0;
      s1_s_q            <= '0;
      s1_c_q            <= '0;
      s1_ids_q          <= '0;
      s1_merge_q        <= 1'b0;
      carry_valid_q     <= 1'b0;
      carry_sum_q       <= '0;
      carry_id_q        <= '0;
      out_valid_q       <= 1'b0;
      out_sums_q        <= '0;
      out_sum_valid_q   <= '0;
      out_ids_q         <= '0;
      out_spill_valid_q <= 1'b0;
      out_spill_sum_q   <= '0;
      out_spill_id_q    <= '0;
    end else if (!stall) begin
      s1_valid_q        <= in_valid;
      s1_end_q          <= end_d;
      s1_s_q            <= cs_s_d;
      s1_c_q            <= cs_c_d;
      s1_ids_q          <= id_w;
      s1_merge_q        <= s1_merge_d;
      carry_valid_q     <= carry_valid_d;
      carry_sum_q       <= carry_sum_d;
      carry_id_q        <= carry_id_d;
      out_valid_q       <= s1_valid_q;
      out_sums_q        <= sums_d;
      out_sum_valid_q   <= sum_valid_d;
      out_ids_q         <= s1_valid_q ? s1_ids_q : '0;
      out_spill_valid_q <= spill_d;
      out_spill_sum_q   <= spill_d ? carry_sum_q : '0;
      out_spill_id_q    <= spill_d ? carry_id_q : '0;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_sums        = out_sums_q;
  assign out_sum_valid   = out_sum_valid_q;
  assign out_vec_ids     = out_ids_q;
  assign out_spill_valid = out_spill_valid_q;
  assign out_spill_sum   = out_spill_sum_q;
  assign out_spill_id    = out_spill_id_q;

endmodule

// File: tb/tb_csa_fan_stream.sv
// Bench for csa_fan_stream: directed scenarios plus random beats
// against a run-sum reference model with carried state.
module tb_csa_fan_stream;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int V   = 3;
  localparam int EXT = 4;
  localparam int S   = W + $clog2(N) + EXT;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_operands = '0;
  logic [N*V-1:0] in_vec_ids = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N*S-1:0] out_sums;
  logic [N-1:0]   out_sum_valid;
  logic [N*V-1:0] out_vec_ids;
  logic           out_spill_valid;
  logic [S-1:0]   out_spill_sum;
  logic [V-1:0]   out_spill_id;

  csa_fan_stream #(.N(N), .W(W), .V(V), .EXT(EXT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operands(in_operands), .in_vec_ids(in_vec_ids),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sums(out_sums), .out_sum_valid(out_sum_valid),
    .out_vec_ids(out_vec_ids),
    .out_spill_valid(out_spill_valid),
    .out_spill_sum(out_spill_sum),
    .out_spill_id(out_spill_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*S-1:0] sums;
    logic [N-1:0]   sv;
    logic [N*V-1:0] ids;
    logic           sp;
    logic [S-1:0]   ssum;
    logic [V-1:0]   sid;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  bit          m_cv = 1'b0;
  int unsigned m_csum = 0;
  int unsigned m_cid = 0;

  logic [N*S-1:0] last_sums = '0;
  logic           last_sp = 1'b0;
  logic [S-1:0]   last_ssum = '0;
  logic [V-1:0]   last_sid = '0;
  bit             rnd_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Running total restarts whenever the id changes; a continuing
  // carry seeds lane 0 when its id matches.
  function automatic exp_t model(input logic [N*W-1:0] ops,
                                 input logic [N*V-1:0] ids,
                                 input logic last);
    exp_t        e;
    int unsigned run;
    int unsigned idj;
    int unsigned mask;
    bit          closes;
    e    = '0;
    e.ids = ids;
    run  = 0;
    mask = (1 << S) - 1;
    for (int j = 0; j < N; j++) begin
      idj = ids[j*V +: V];
      if (j == 0) begin
        run = (m_cv && idj == m_cid) ? m_csum : 0;
      end else if (idj != ids[(j-1)*V +: V]) begin
        run = 0;
      end
      run = (run + ops[j*W +: W]) & mask;
      if (j == N - 1) closes = last;
      else closes = idj != ids[(j+1)*V +: V];
      if (closes) begin
        e.sv[j] = 1'b1;
        e.sums[j*S +: S] = run[S-1:0];
      end
    end
    if (m_cv && ids[V-1:0] != m_cid[V-1:0]) begin
      e.sp   = 1'b1;
      e.ssum = m_csum[S-1:0];
      e.sid  = m_cid[V-1:0];
    end
    if (last) begin
      m_cv = 1'b0;
    end else begin
      m_cv   = 1'b1;
      m_csum = run;
      m_cid  = ids[(N-1)*V +: V];
    end
    return e;
  endfunction

  initial begin : monitor
    bit   rst_prev;
    exp_t e;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum_valid", out_sum_valid, 0);
        chk("rst_spill", out_spill_valid, 0);
        chk("rst_sums", out_sums, 0);
      end
      if (rst) begin
        chk("rst_in_ready", in_ready, 0);
        q.delete();
        m_cv = 1'b0;
        m_csum = 0;
        m_cid = 0;
      end else begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("stale_out", out_valid, 0);
          end else begin
            e = q[0];
            chk("sums", out_sums, e.sums);
            chk("sum_valid", out_sum_valid, e.sv);
            chk("vec_ids", out_vec_ids, e.ids);
            chk("spill_valid", out_spill_valid, e.sp);
            chk("spill_sum", out_spill_sum, e.ssum);
            chk("spill_id", out_spill_id, e.sid);
            if (out_ready) begin
              void'(q.pop_front());
              last_sums = out_sums;
              last_sp   = out_spill_valid;
              last_ssum = out_spill_sum;
              last_sid  = out_spill_id;
            end
          end
        end
        if (in_valid && in_ready)
          q.push_back(model(in_operands, in_vec_ids, in_last));
      end
      rst_prev = rst;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = $urandom_range(0, 3) != 0;
    end
  end

  task automatic send(input logic [N*V-1:0] ids,
                      input logic [N*W-1:0] ops, input logic last);
    bit done;
    done = 1'b0;
    in_valid    = 1'b1;
    in_vec_ids  = ids;
    in_operands = ops;
    in_last     = last;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*V-1:0] ids;
    logic [N*W-1:0] ops;
    logic [N*S-1:0] xs;
    logic [S-1:0]   l3;
    int             cur;
    int             prev_last_id;
    logic           lst;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send({3'd1, 3'd1, 3'd0, 3'd0}, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    drain();
    xs = '0;
    xs[3*S +: S] = S'(7);
    xs[1*S +: S] = S'(3);
    chk("single_sums", last_sums, xs);
    chk("single_spill", last_sp, 0);

    send({3'd2, 3'd2, 3'd2, 3'd2}, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
    send({3'd3, 3'd3, 3'd3, 3'd2}, {8'd1, 8'd1, 8'd1, 8'd5}, 1'b1);
    drain();
    chk("merge_lane0", last_sums[S-1:0], 105);
    l3 = last_sums[3*S +: S];
    chk("merge_lane3", l3, 3);
    chk("merge_spill", last_sp, 0);

    send({3'd1, 3'd1, 3'd0, 3'd0}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    send({3'd5, 3'd5, 3'd5, 3'd5}, {8'd2, 8'd2, 8'd2, 8'd2}, 1'b1);
    drain();
    chk("spill_valid_d", last_sp, 1);
    chk("spill_sum_d", last_ssum, 2);
    chk("spill_id_d", last_sid, 1);
    l3 = last_sums[3*S +: S];
    chk("spill_lane3", l3, 8);

    out_ready = 1'b0;
    fork
      begin
        send({3'd0, 3'd0, 3'd0, 3'd0}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1);
        send({3'd6, 3'd6, 3'd7, 3'd7}, {8'd9, 8'd8, 8'd7, 8'd6}, 1'b1);
        send({3'd4, 3'd3, 3'd2, 3'd1}, {8'd200, 8'd100, 8'd50, 8'd25}, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    drain();
    l3 = last_sums[3*S +: S];
    chk("bp_last_lane3", l3, 200);

    for (int b = 0; b < 17; b++)
      send({4{3'd4}}, {4{8'd255}}, b == 16);
    drain();
    l3 = last_sums[3*S +: S];
    chk("wrap_lane3", l3, 956);

    send({4{3'd2}}, {4{8'd7}}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send({4{3'd2}}, {4{8'd1}}, 1'b1);
    drain();
    l3 = last_sums[3*S +: S];
    chk("rst_run_lane3", l3, 4);
    chk("rst_run_spill", last_sp, 0);

    rnd_en = 1'b1;
    prev_last_id = 0;
    lst = 1'b1;
    for (int b = 0; b < 250; b++) begin
      if (!lst && $urandom_range(0, 1) == 1) cur = prev_last_id;
      else cur = $urandom_range(0, 7);
      for (int l = 0; l < N; l++) begin
        if (l > 0 && $urandom_range(0, 2) == 0) cur = (cur + 1) % 8;
        ids[l*V +: V] = V'(cur);
        if ($urandom_range(0, 3) == 0) ops[l*W +: W] = 8'd255;
        else ops[l*W +: W] = W'($urandom_range(0, 255));
      end
      lst = $urandom_range(0, 2) == 0;
      prev_last_id = cur;
      send(ids, ops, lst);
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("final_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
